// File: rtl/dvp_pxl_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pxl_mem_writer
//  Purpose  : Packs 8-bit DVP pixels into 32-bit words, buffers them in a FIFO
//             and writes each frame to memory as fixed-length AXI4 INCR bursts.
//  Options  : DVP_PXL_WR_FRAME_CNT_EN adds the 16-bit frame_cnt_o counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pxl_mem_writer #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 32,
    parameter int MST_ID_W          = 5,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RESP_W      = 2,
    parameter int PXL_W             = 8,
    parameter int BURST_LEN         = 16,
    parameter int FIFO_DEPTH        = 32,
    parameter int FRAME_WORDS       = 19200,
    parameter logic [MST_ID_W-1:0] MST_ID = MST_ID_W'(2)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  dvp_conf_i,
    input  logic [ADDR_W-1:0]            pxl_mem_base_i,
    input  logic [PXL_W-1:0]             pxl_data_i,
    input  logic                         pxl_sof_i,
    input  logic                         pxl_valid_i,
    output logic                         pxl_ready_o,
    output logic [MST_ID_W-1:0]          m_awid_o,
    output logic [ADDR_W-1:0]            m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0]  m_awlen_o,
    output logic [TRANS_DATA_SIZE_W-1:0] m_awsize_o,
    output logic                         m_awvalid_o,
    input  logic                         m_awready_i,
    output logic [DATA_W-1:0]            m_wdata_o,
    output logic                         m_wlast_o,
    output logic                         m_wvalid_o,
    input  logic                         m_wready_i,
    input  logic [MST_ID_W-1:0]          m_bid_i,
    input  logic [TRANS_RESP_W-1:0]      m_bresp_i,
    input  logic                         m_bvalid_i,
    output logic                         m_bready_o,
    output logic                         frame_done_o,
    output logic                         err_o
`ifdef DVP_PXL_WR_FRAME_CNT_EN
    ,
    output logic [15:0]                  frame_cnt_o
`endif
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_beat_w = $clog2(BURST_LEN + 1);
    localparam int c_fw_w   = $clog2(FRAME_WORDS + 1);
    localparam int c_pack_w = DATA_W - PXL_W;

    localparam logic [c_cnt_w-1:0]  c_fifo_full   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_burst_words = c_cnt_w'(BURST_LEN);
    localparam logic [c_beat_w-1:0] c_last_beat   = c_beat_w'(BURST_LEN - 1);
    localparam logic [c_fw_w-1:0]   c_frm_inc     = c_fw_w'(BURST_LEN);
    localparam logic [c_fw_w-1:0]   c_frm_words   = c_fw_w'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0]   c_burst_bytes = ADDR_W'(BURST_LEN * (DATA_W / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_rdy_en;
    logic                  r_cap_en;
    logic [1:0]            r_byte_idx;
    logic [c_pack_w-1:0]   r_pack;

    logic [DATA_W-1:0]     r_fifo [FIFO_DEPTH];
    logic [c_ptr_w:0]      r_wr_ptr;
    logic [c_ptr_w:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]    w_fifo_cnt;
    logic                  w_fifo_full;

    logic [ADDR_W-1:0]     r_wr_addr;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [c_beat_w-1:0]   r_beat;
    logic [c_fw_w-1:0]     r_frm_words;
    logic                  r_frame_done;
    logic                  r_err;

    logic                  w_pxl_acc;
    logic                  w_sof_acc;
    logic                  w_cap;
    logic [1:0]            w_idx;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_W-1:0]     w_push_word;
    logic                  w_leave_idle;
    logic [ADDR_W-1:0]     w_aw_base;
    logic                  w_b_hs;
    logic                  w_frm_complete;

    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_wlast;
    logic                  w_bready;

    logic                  w_unused_bits;
    assign w_unused_bits = ^{m_bid_i, dvp_conf_i[31:1]};

    // ------------------------------------------------------------------
    // Pixel side: an SOF pixel decides capture for itself and restarts the
    // packer, so enable/index are forwarded from the live inputs.
    // ------------------------------------------------------------------
    assign w_fifo_cnt  = r_wr_ptr - r_rd_ptr;
    assign w_fifo_full = (w_fifo_cnt == c_fifo_full);

    assign pxl_ready_o = r_rdy_en & ~(r_cap_en & (r_byte_idx == 2'd3) & w_fifo_full);
    assign w_pxl_acc   = pxl_valid_i & pxl_ready_o;
    assign w_sof_acc   = w_pxl_acc & pxl_sof_i;
    assign w_cap       = pxl_sof_i ? dvp_conf_i[0] : r_cap_en;
    assign w_idx       = pxl_sof_i ? 2'd0 : r_byte_idx;
    assign w_push      = w_pxl_acc & w_cap & (w_idx == 2'd3);
    assign w_push_word = {pxl_data_i, r_pack};
    assign w_pop       = w_wvalid & m_wready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en   <= 1'b0;
            r_cap_en   <= 1'b0;
            r_byte_idx <= 2'd0;
            r_pack     <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_sof_acc) begin
                r_cap_en <= dvp_conf_i[0];
            end
            if (w_pxl_acc && w_cap) begin
                // Shift in from the top so the first pixel lands in [7:0].
                r_pack     <= {pxl_data_i, r_pack[c_pack_w-1:PXL_W]};
                r_byte_idx <= w_idx + 2'd1;
            end else if (w_sof_acc) begin
                r_byte_idx <= 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_ptr_w-1:0]] <= w_push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign m_wdata_o = r_fifo[r_rd_ptr[c_ptr_w-1:0]];

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_wlast     = 1'b0;
        w_bready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_cnt >= c_burst_words) begin
                    w_state_nxt = S_AW;
                end
            end
            S_AW: begin
                w_awvalid = 1'b1;
                if (m_awready_i) begin
                    w_state_nxt = S_W;
                end
            end
            S_W: begin
                w_wvalid = 1'b1;
                w_wlast  = (r_beat == c_last_beat);
                if (m_wready_i && w_wlast) begin
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                w_bready = 1'b1;
                if (m_bvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign m_awvalid_o = w_awvalid;
    assign m_wvalid_o  = w_wvalid;
    assign m_wlast_o   = w_wlast;
    assign m_bready_o  = w_bready;
    assign m_awid_o    = MST_ID;
    assign m_awaddr_o  = r_awaddr;
    assign m_awlen_o   = TRANS_DATA_LEN_W'(BURST_LEN - 1);
    assign m_awsize_o  = TRANS_DATA_SIZE_W'(2);

    // ------------------------------------------------------------------
    // Address, beat, frame and error tracking. The burst address is frozen
    // when the burst is committed so AWADDR stays stable under AWVALID; an
    // SOF in that same cycle already redirects the committed burst.
    // ------------------------------------------------------------------
    assign w_leave_idle   = (r_state == S_IDLE) && (w_state_nxt == S_AW);
    assign w_aw_base      = w_sof_acc ? pxl_mem_base_i : r_wr_addr;
    assign w_b_hs         = w_bready & m_bvalid_i;
    assign w_frm_complete = ((r_frm_words + c_frm_inc) == c_frm_words);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_awaddr     <= '0;
            r_beat       <= '0;
            r_frm_words  <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_leave_idle) begin
                r_awaddr  <= w_aw_base;
                r_wr_addr <= w_aw_base + c_burst_bytes;
            end else if (w_sof_acc) begin
                r_wr_addr <= pxl_mem_base_i;
            end

            if (w_pop) begin
                r_beat <= w_wlast ? '0 : r_beat + c_beat_w'(1);
            end

            if (w_sof_acc) begin
                r_frm_words <= '0;
            end else if (w_b_hs) begin
                r_frm_words <= w_frm_complete ? '0 : r_frm_words + c_frm_inc;
            end

            r_frame_done <= w_b_hs & w_frm_complete;

            if (w_sof_acc) begin
                r_err <= 1'b0;
            end else if (w_b_hs && (m_bresp_i != '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;

`ifdef DVP_PXL_WR_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (r_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvp_pxl_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_pxl_mem_writer
//  Purpose  : Scoreboard bench for dvp_pxl_mem_writer (64-word frames).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_pxl_mem_writer;

    localparam int c_bl = 16;
    localparam int c_fw = 64;

    logic        clk;
    logic        rst;
    logic [31:0] dvp_conf_i;
    logic [31:0] pxl_mem_base_i;
    logic [7:0]  pxl_data_i;
    logic        pxl_sof_i;
    logic        pxl_valid_i;
    logic        pxl_ready_o;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic [2:0]  m_awsize_o;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_wdata_o;
    logic        m_wlast_o;
    logic        m_wvalid_o;
    logic        m_wready_i;
    logic [4:0]  m_bid_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i;
    logic        m_bready_o;
    logic        frame_done_o;
    logic        err_o;

    dvp_pxl_mem_writer #(
        .BURST_LEN   (c_bl),
        .FIFO_DEPTH  (32),
        .FRAME_WORDS (c_fw)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .dvp_conf_i     (dvp_conf_i),
        .pxl_mem_base_i (pxl_mem_base_i),
        .pxl_data_i     (pxl_data_i),
        .pxl_sof_i      (pxl_sof_i),
        .pxl_valid_i    (pxl_valid_i),
        .pxl_ready_o    (pxl_ready_o),
        .m_awid_o       (m_awid_o),
        .m_awaddr_o     (m_awaddr_o),
        .m_awlen_o      (m_awlen_o),
        .m_awsize_o     (m_awsize_o),
        .m_awvalid_o    (m_awvalid_o),
        .m_awready_i    (m_awready_i),
        .m_wdata_o      (m_wdata_o),
        .m_wlast_o      (m_wlast_o),
        .m_wvalid_o     (m_wvalid_o),
        .m_wready_i     (m_wready_i),
        .m_bid_i        (m_bid_i),
        .m_bresp_i      (m_bresp_i),
        .m_bvalid_i     (m_bvalid_i),
        .m_bready_o     (m_bready_o),
        .frame_done_o   (frame_done_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    logic [31:0] q_aw [$];
    logic [32:0] q_w  [$];

    int wlast_cnt = 0;
    int b_hs_cnt  = 0;
    int b_issue   = 0;
    int b_seen    = 0;
    int err_tgt   = -1;
    int aw_seen   = 0;
    int fd_seen   = 0;
    bit exp_err   = 1'b0;
    bit en0_phase = 1'b0;
    int en0_rdy_low   = 0;
    bit stall_phase   = 1'b0;
    int stall_rdy_low = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vec++;
        miss++;
        $display("FAIL %s: event not as expected", nm);
    endtask

    // Monitor: pops expectations on every handshake, tracks the error flag.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [32:0] ew;
        if (rst) begin
            exp_err = 1'b0;
        end else begin
            chk("err_o", err_o, exp_err);
            if (m_awvalid_o && m_awready_i) begin
                aw_seen++;
                if (q_aw.size() == 0) begin
                    fail("aw_unexpected");
                end else begin
                    ea = q_aw.pop_front();
                    chk("awaddr", m_awaddr_o, ea);
                    chk("awlen", m_awlen_o, 8'd15);
                    chk("awsize", m_awsize_o, 3'b010);
                    chk("awid", m_awid_o, 5'h02);
                end
            end
            if (m_wvalid_o && m_wready_i) begin
                if (q_w.size() == 0) begin
                    fail("w_unexpected");
                end else begin
                    ew = q_w.pop_front();
                    chk("wdata", m_wdata_o, ew[31:0]);
                    chk("wlast", m_wlast_o, ew[32]);
                end
                if (m_wlast_o) wlast_cnt++;
            end
            if (m_bvalid_i && m_bready_o) begin
                b_hs_cnt++;
                if (m_bresp_i != 2'b00) exp_err = 1'b1;
            end
            if (pxl_valid_i && pxl_ready_o && pxl_sof_i) exp_err = 1'b0;
            if (frame_done_o) fd_seen++;
            if (en0_phase && !pxl_ready_o) en0_rdy_low++;
            if (stall_phase && pxl_valid_i && !pxl_ready_o) stall_rdy_low++;
        end
    end

    // Write-response responder: one response per completed burst.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_bvalid_i = 1'b0;
            b_issue    = wlast_cnt;
            b_seen     = b_hs_cnt;
        end else if (m_bvalid_i) begin
            if (b_hs_cnt > b_seen) begin
                b_seen     = b_hs_cnt;
                m_bvalid_i = 1'b0;
            end
        end else if (wlast_cnt > b_issue) begin
            b_issue++;
            m_bvalid_i = 1'b1;
            m_bresp_i  = (b_issue == err_tgt) ? 2'b10 : 2'b00;
        end
    end

    task automatic send_pix(input logic [7:0] pix, input logic sof);
        int t;
        pxl_data_i  = pix;
        pxl_sof_i   = sof;
        pxl_valid_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!pxl_ready_o && t < 2000);
        if (!pxl_ready_o) fail("pixel_accept_timeout");
        @(posedge clk);
        #1;
        pxl_valid_i = 1'b0;
        pxl_sof_i   = 1'b0;
    endtask

    // Drives a frame and pushes the expected bursts it should produce.
    task automatic send_frame(input logic [31:0] base, input logic en, input int npix, input int pat);
        logic [31:0] addr;
        logic [31:0] word;
        logic [7:0]  pix;
        int nw;
        dvp_conf_i     = {31'b0, en};
        pxl_mem_base_i = base;
        addr = base;
        word = '0;
        nw   = 0;
        for (int i = 0; i < npix; i++) begin
            pix = (pat == 0) ? 8'(i) : 8'(i * 7 + pat * 13);
            send_pix(pix, i == 0);
            if (en) begin
                word = {pix, word[31:8]};
                if (i % 4 == 3) begin
                    q_w.push_back({(nw % c_bl == c_bl - 1), word});
                    nw++;
                    if (nw % c_bl == 0) begin
                        q_aw.push_back(addr);
                        addr = addr + 32'd64;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_aw.size() != 0 || q_w.size() != 0 || m_bvalid_i || wlast_cnt > b_issue) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) fail("drain_timeout");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fd0;
        int aw0;
        int t;
        rst = 1'b1;
        dvp_conf_i = '0;
        pxl_mem_base_i = '0;
        pxl_data_i = '0;
        pxl_sof_i = 1'b0;
        pxl_valid_i = 1'b0;
        m_awready_i = 1'b1;
        m_wready_i = 1'b1;
        m_bid_i = '0;
        m_bresp_i = '0;
        m_bvalid_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pxl_ready", pxl_ready_o, 1'b0);
        chk("rst_awvalid", m_awvalid_o, 1'b0);
        chk("rst_wvalid", m_wvalid_o, 1'b0);
        chk("rst_wlast", m_wlast_o, 1'b0);
        chk("rst_bready", m_bready_o, 1'b0);
        chk("rst_frame_done", frame_done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", pxl_ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Basic frame: 0x00..0xFF at 0x8000_0000.
        fd0 = fd_seen;
        send_frame(32'h8000_0000, 1'b1, 256, 0);
        drain();
        chk("p1_frame_done", fd_seen, fd0 + 1);

        // Long write stall: FIFO fills, pixel input must back-pressure.
        fd0 = fd_seen;
        stall_phase = 1'b1;
        fork
            send_frame(32'h8000_1000, 1'b1, 256, 1);
            begin
                repeat (60) @(posedge clk);
                #1 m_wready_i = 1'b0;
                repeat (150) @(posedge clk);
                #1 m_wready_i = 1'b1;
            end
        join
        stall_phase = 1'b0;
        drain();
        chk("p2_backpressure_seen", stall_rdy_low > 0, 1'b1);
        chk("p2_frame_done", fd_seen, fd0 + 1);

        // Capture disabled.
        fd0 = fd_seen;
        aw0 = aw_seen;
        en0_phase = 1'b1;
        send_frame(32'h8000_2000, 1'b0, 256, 2);
        en0_phase = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("p3_ready_low_cycles", en0_rdy_low, 0);
        chk("p3_aw_count", aw_seen, aw0);
        chk("p3_frame_done", fd_seen, fd0);

        // Error response on the second burst.
        fd0 = fd_seen;
        err_tgt = b_issue + 2;
        send_frame(32'hA000_0000, 1'b1, 256, 3);
        drain();
        chk("p4_err_held", err_o, 1'b1);
        chk("p4_frame_done", fd_seen, fd0 + 1);

        // Truncated frame then a new base.
        fd0 = fd_seen;
        send_frame(32'h8000_2000, 1'b1, 128, 4);
        drain();
        chk("p5_err_cleared", err_o, 1'b0);
        chk("p5_short_frame_done", fd_seen, fd0);
        send_frame(32'h9000_0000, 1'b1, 256, 5);
        drain();
        chk("p5_frame_done", fd_seen, fd0 + 1);

        // Reset while a burst is stuck in the data phase.
        m_wready_i = 1'b0;
        send_frame(32'hB000_0000, 1'b1, 64, 6);
        t = 0;
        while (!m_wvalid_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!m_wvalid_o) fail("p6_wphase_timeout");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("p6_rst_pxl_ready", pxl_ready_o, 1'b0);
        chk("p6_rst_awvalid", m_awvalid_o, 1'b0);
        chk("p6_rst_wvalid", m_wvalid_o, 1'b0);
        chk("p6_rst_wlast", m_wlast_o, 1'b0);
        chk("p6_rst_bready", m_bready_o, 1'b0);
        chk("p6_rst_frame_done", frame_done_o, 1'b0);
        q_aw.delete();
        q_w.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_wready_i = 1'b1;
        fd0 = fd_seen;
        send_frame(32'hC000_0000, 1'b1, 256, 7);
        drain();
        chk("p6_frame_done", fd_seen, fd0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
